// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the interrupt controller.
// Source indices double as bit positions in the pending/overflow vectors.
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        SERVICE = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic SRC_KEY = 1'b0;
    localparam logic SRC_ETH = 1'b1;
    localparam int   NUM_SRC = 2;

endpackage

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous request line followed by a
// rising-edge detector that yields a single-cycle pulse.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_in};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/irq_ctrl.sv
// Two-source interrupt controller: pending/payload capture, arbitration, grant
// pulse and post-service quiet gap. Define IRQ_ROUND_ROBIN_EN for round-robin.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              irq_key_async,
    input  logic              irq_eth_async,
    input  logic [DATA_W-1:0] key_data,
    input  logic [DATA_W-1:0] eth_data,
    input  logic              rti,
    input  logic              rsi,
    output logic              interrupt,
    output logic [DATA_W-1:0] interrupt_source_data,
    output logic              src_id,
    output logic [1:0]        pending,
    output logic [1:0]        overflow,
    input  logic              overflow_clr
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    logic [NUM_SRC-1:0] req_async;
    logic [NUM_SRC-1:0] rise;
    logic [DATA_W-1:0]  src_data [NUM_SRC];

    logic [NUM_SRC-1:0] pending_reg,  pending_next;
    logic [NUM_SRC-1:0] overflow_reg, overflow_next;
    logic [NUM_SRC-1:0] capture;
    logic [NUM_SRC-1:0] grant_clr;
    logic [DATA_W-1:0]  buf_reg [NUM_SRC];

    state_t             state_reg, state_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic               irq_reg, irq_next;
    logic [DATA_W-1:0]  data_reg, data_next;
    logic               src_reg, src_next;
    logic               winner;
    logic               grant;

    assign req_async          = {irq_eth_async, irq_key_async};
    assign src_data[SRC_KEY]  = key_data;
    assign src_data[SRC_ETH]  = eth_data;

    // A new edge always wins over a same-cycle grant clear, and a clear
    // makes room for the new payload instead of counting as an overflow.
    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            irq_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync (
                .clk     (clk),
                .rst_n   (rst_n),
                .async_in(req_async[gi]),
                .rise    (rise[gi])
            );

            assign capture[gi]       = rise[gi] & (~pending_reg[gi] | grant_clr[gi]);
            assign pending_next[gi]  = (pending_reg[gi] & ~grant_clr[gi]) | rise[gi];
            assign overflow_next[gi] = (overflow_reg[gi] & ~overflow_clr)
                                     | (rise[gi] & pending_reg[gi] & ~grant_clr[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_reg  <= '0;
            overflow_reg <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (capture[i]) begin
                    buf_reg[i] <= src_data[i];
                end
            end
        end
    end

`ifdef IRQ_ROUND_ROBIN_EN
    logic last_grant_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= SRC_KEY;
        end else if (grant) begin
            last_grant_reg <= winner;
        end
    end

    always_comb begin
        if (pending_reg[SRC_KEY] && pending_reg[SRC_ETH]) begin
            winner = ~last_grant_reg;
        end else begin
            winner = pending_reg[SRC_ETH] ? SRC_ETH : SRC_KEY;
        end
    end
`else
    assign winner = pending_reg[SRC_ETH] ? SRC_ETH : SRC_KEY;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gap_reg   <= '0;
            irq_reg   <= 1'b0;
            data_reg  <= '0;
            src_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            gap_reg   <= gap_next;
            irq_reg   <= irq_next;
            data_reg  <= data_next;
            src_reg   <= src_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        irq_next   = 1'b0;
        data_next  = data_reg;
        src_next   = src_reg;
        grant_clr  = '0;
        grant      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|pending_reg) begin
                    state_next        = GRANT;
                    irq_next          = 1'b1;
                    data_next         = buf_reg[winner];
                    src_next          = winner;
                    grant_clr[winner] = 1'b1;
                    grant             = 1'b1;
                end
            end
            GRANT: begin
                state_next = SERVICE;
            end
            SERVICE: begin
                if (rti || rsi) begin
                    state_next = GAP;
                    gap_next   = GAP_W'(GAP_CYCLES);
                end
            end
            GAP: begin
                // The cycle in which the count reaches zero is the last gap cycle.
                if (gap_reg <= GAP_W'(1)) begin
                    gap_next   = '0;
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign interrupt             = irq_reg;
    assign interrupt_source_data = data_reg;
    assign src_id                = src_reg;
    assign pending               = pending_reg;
    assign overflow              = overflow_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a table of single/dual-source transactions
// plus hand sequences for overflow, same-cycle clear/set and mid-service reset.
module tb_irq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        irq_key_async;
    logic        irq_eth_async;
    logic [31:0] key_data;
    logic [31:0] eth_data;
    logic        rti;
    logic        rsi;
    logic        interrupt;
    logic [31:0] interrupt_source_data;
    logic        src_id;
    logic [1:0]  pending;
    logic [1:0]  overflow;
    logic        overflow_clr;

    int errors = 0;
    int checks = 0;

    irq_ctrl #(
        .SYNC_STAGES(2),
        .GAP_CYCLES (2),
        .DATA_W     (32)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .irq_key_async        (irq_key_async),
        .irq_eth_async        (irq_eth_async),
        .key_data             (key_data),
        .eth_data             (eth_data),
        .rti                  (rti),
        .rsi                  (rsi),
        .interrupt            (interrupt),
        .interrupt_source_data(interrupt_source_data),
        .src_id               (src_id),
        .pending              (pending),
        .overflow             (overflow),
        .overflow_clr         (overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        key_rise;
        logic        eth_rise;
        logic [31:0] kd;
        logic [31:0] ed;
        logic        use_rti;
        logic        use_rsi;
        logic        src1;
        logic [31:0] d1;
        logic        two;
        logic        src2;
        logic [31:0] d2;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Returns the number of cycles until interrupt is seen, or -1 after 20.
    task automatic wait_irq(output int n);
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (interrupt) begin
                n = i;
                break;
            end
        end
        $display("grant: after %0d cycles src=%0d data=0x%08h pending=%b overflow=%b",
                 n, src_id, interrupt_source_data, pending, overflow);
    endtask

    task automatic pulse_ret(input logic a, input logic b);
        rti = a;
        rsi = b;
        tick();
        rti = 1'b0;
        rsi = 1'b0;
    endtask

    task automatic settle;
        irq_key_async = 1'b0;
        irq_eth_async = 1'b0;
        ticks(6);
    endtask

    int n;
    int seen;
    int grants;
    int grant_at;
    logic        g_src;
    logic [31:0] g_data;

    initial begin
        rst_n         = 1'b0;
        irq_key_async = 1'b0;
        irq_eth_async = 1'b0;
        key_data      = '0;
        eth_data      = '0;
        rti           = 1'b0;
        rsi           = 1'b0;
        overflow_clr  = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_00A5, 32'h0, 1'b1, 1'b0,
                    1'b0, 32'h0000_00A5, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h1234_5678, 1'b0, 1'b1,
                    1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
`ifdef IRQ_ROUND_ROBIN_EN
        vecs[2] = '{1'b1, 1'b1, 32'h0000_00A5, 32'h1234_5678, 1'b1, 1'b0,
                    1'b0, 32'h0000_00A5, 1'b1, 1'b1, 32'h1234_5678};
`else
        vecs[2] = '{1'b1, 1'b1, 32'h0000_00A5, 32'h1234_5678, 1'b1, 1'b0,
                    1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0000_00A5};
`endif
        vecs[3] = '{1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b1,
                    1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};

        ticks(3);
        chk("reset_interrupt", {31'b0, interrupt}, 32'h0);
        chk("reset_data", interrupt_source_data, 32'h0);
        chk("reset_pending_overflow", {28'b0, pending, overflow}, 32'h0);
        rst_n = 1'b1;
        ticks(2);

        // Table-driven transactions
        for (int v = 0; v < 4; v++) begin
            key_data = vecs[v].kd;
            eth_data = vecs[v].ed;
            ticks(3);
            irq_key_async = vecs[v].key_rise;
            irq_eth_async = vecs[v].eth_rise;
            wait_irq(n);
            chk($sformatf("v%0d_latency", v), n, 32'd4);
            chk($sformatf("v%0d_src1", v), {31'b0, src_id}, {31'b0, vecs[v].src1});
            chk($sformatf("v%0d_data1", v), interrupt_source_data, vecs[v].d1);
            tick();
            chk($sformatf("v%0d_pulse_width", v), {31'b0, interrupt}, 32'h0);
            ticks(3);
            chk($sformatf("v%0d_data_held", v), interrupt_source_data, vecs[v].d1);
            if (vecs[v].two)
                chk($sformatf("v%0d_other_pending", v), {30'b0, pending},
                    vecs[v].src1 ? 32'h1 : 32'h2);
            pulse_ret(vecs[v].use_rti, vecs[v].use_rsi);
            if (vecs[v].two) begin
                wait_irq(n);
                chk($sformatf("v%0d_gap", v), n, 32'd3);
                chk($sformatf("v%0d_src2", v), {31'b0, src_id}, {31'b0, vecs[v].src2});
                chk($sformatf("v%0d_data2", v), interrupt_source_data, vecs[v].d2);
                ticks(2);
                pulse_ret(1'b1, 1'b0);
            end
            seen = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (interrupt) seen++;
            end
            chk($sformatf("v%0d_no_extra", v), seen, 32'd0);
            settle();
        end

        // rti/rsi while idle must do nothing
        rti = 1'b1;
        rsi = 1'b1;
        ticks(2);
        rti = 1'b0;
        rsi = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (interrupt) seen++;
        end
        chk("idle_rti_no_irq", seen, 32'd0);
        chk("idle_rti_pending", {30'b0, pending}, 32'h0);

        // Overflow: two eth edges during a key service
        key_data = 32'h0000_00B0;
        eth_data = 32'h0000_0011;
        ticks(3);
        irq_key_async = 1'b1;
        wait_irq(n);
        chk("ovf_key_src", {31'b0, src_id}, 32'h0);
        irq_eth_async = 1'b1;
        ticks(4);
        chk("ovf_first_pending", {30'b0, pending}, 32'h2);
        irq_eth_async = 1'b0;
        eth_data = 32'h0000_0022;
        ticks(4);
        irq_eth_async = 1'b1;
        ticks(4);
        chk("ovf_pending", {30'b0, pending}, 32'h2);
        chk("ovf_overflow", {30'b0, overflow}, 32'h2);
        chk("ovf_service_data_held", interrupt_source_data, 32'h0000_00B0);
        pulse_ret(1'b1, 1'b0);
        wait_irq(n);
        chk("ovf_grant_gap", n, 32'd3);
        chk("ovf_grant_src", {31'b0, src_id}, 32'h1);
        chk("ovf_grant_first_payload", interrupt_source_data, 32'h0000_0011);
        chk("ovf_sticky", {30'b0, overflow}, 32'h2);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("ovf_cleared", {30'b0, overflow}, 32'h0);
        tick();
        pulse_ret(1'b1, 1'b0);
        settle();
        chk("ovf_end_pending", {30'b0, pending}, 32'h0);

        // New key edge in the very cycle its pending is cleared by a grant
        key_data = 32'h0000_0055;
        eth_data = 32'h0000_00E0;
        ticks(3);
        irq_eth_async = 1'b1;
        wait_irq(n);
        chk("same_eth_src", {31'b0, src_id}, 32'h1);
        irq_key_async = 1'b1;
        ticks(4);
        chk("same_key_pending", {30'b0, pending}, 32'h1);
        irq_key_async = 1'b0;
        key_data = 32'h0000_0077;
        ticks(4);
        rti = 1'b1;
        tick();
        rti = 1'b0;
        irq_key_async = 1'b1;
        wait_irq(n);
        chk("same_grant_cycle", n, 32'd3);
        chk("same_grant_src", {31'b0, src_id}, 32'h0);
        chk("same_grant_data", interrupt_source_data, 32'h0000_0055);
        tick();
        chk("same_pending_after", {30'b0, pending}, 32'h1);
        chk("same_overflow_after", {30'b0, overflow}, 32'h0);
        pulse_ret(1'b1, 1'b0);
        wait_irq(n);
        chk("same_second_src", {31'b0, src_id}, 32'h0);
        chk("same_second_data", interrupt_source_data, 32'h0000_0077);
        tick();
        pulse_ret(1'b1, 1'b0);
        settle();

        // Reset in the middle of a service with key pending
        key_data = 32'h0000_0033;
        eth_data = 32'h0000_00E1;
        ticks(3);
        irq_key_async = 1'b1;
        irq_eth_async = 1'b1;
        wait_irq(n);
        ticks(2);
        chk("rst_pre_pending", {30'b0, pending}, 32'h1);
        rst_n = 1'b0;
        irq_eth_async = 1'b0;
        #1;
        chk("rst_interrupt", {31'b0, interrupt}, 32'h0);
        chk("rst_src", {31'b0, src_id}, 32'h0);
        chk("rst_data", interrupt_source_data, 32'h0);
        chk("rst_pending_overflow", {28'b0, pending, overflow}, 32'h0);
        ticks(2);
        rst_n = 1'b1;
        grants = 0;
        grant_at = -10;
        g_src = 1'b1;
        g_data = '0;
        for (int i = 0; i < 30; i++) begin
            rti = (i == grant_at + 3);
            tick();
            if (interrupt) begin
                grants++;
                grant_at = i;
                g_src = src_id;
                g_data = interrupt_source_data;
                $display("grant: post-reset cycle %0d src=%0d data=0x%08h", i, src_id,
                         interrupt_source_data);
            end
        end
        rti = 1'b0;
        chk("rst_regrant_count", grants, 32'd1);
        chk("rst_regrant_src", {31'b0, g_src}, 32'h0);
        chk("rst_regrant_data", g_data, 32'h0000_0033);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
